dsadc_mod_counter: RTL
======================

// Module: dsadc_mod_counter
// PURPOSE
//   Parametrised modulus counter for the dual-slope ADC (DSADC) timing path: next generation of the basic enable/max counter.
//   Adds up/down counting, a runtime-programmable terminal value, synchronous clear/load, a cascade carry chain,
//   a sticky overflow flag and a capture register that latches the count at comparator trip.
//   Drives both the fixed integrate interval and the de-integrate conversion count.
// PARAMETERS
//   WIDTH      4   counter, load, terminal and capture width in bits
//   MAX_COUNT  10  reset modulus; terminal register resets to MAX_COUNT-1; legal range 2..2**WIDTH (elaboration error otherwise)
// PORTS
//   clk       in   1      clock; all state updates on posedge
//   rst_s_n   in   1      asynchronous, active-low reset
//   enb       in   1      count enable
//   cin       in   1      cascade carry-in; a step occurs only when enb & cin (tie 1 if unused)
//   dir       in   1      0 = count up, 1 = count down
//   clr       in   1      synchronous clear of q and ovf
//   load      in   1      synchronous load of q from load_val
//   load_val  in   WIDTH  load value
//   term_wr   in   1      synchronous write of terminal register from term_val
//   term_val  in   WIDTH  new terminal value (count range becomes 0..term_val)
//   cap       in   1      capture strobe (comparator trip)
//   q         out  WIDTH  current count
//   at_max    out  1      comb: (dir=0 & q>=term) | (dir=1 & q==0)
//   cout      out  1      comb: at_max & enb & cin (carry to next stage)
//   wrap      out  1      registered one-cycle pulse, high the cycle after a wrap step
//   ovf       out  1      sticky: set on any wrap; cleared only by clr or reset
//   q_cap     out  WIDTH  captured count
//   cap_vld   out  1      registered one-cycle pulse, high the cycle after cap
// BEHAVIOUR
//   Reset (rst_s_n=0, async, immediate):
//     q=0, term=MAX_COUNT-1, wrap=0, ovf=0, q_cap=0, cap_vld=0. Outputs hold until the first posedge after deassertion.
//   q update priority per edge: clr > load > step (step = enb & cin) > hold.
//     clr: q<=0, ovf<=0, wrap<=0; overrides load and step in the same cycle.
//     load: q<=load_val, no wrap, ovf unchanged. load_val > term is accepted.
//   Step up (dir=0):
//     q<term: q<=q+1.
//     q>=term: q<=0, wrap<=1, ovf<=1. Covers q left above term by load or term_wr: the next up-step wraps to 0.
//   Step down (dir=1):
//     q>0: q<=q-1, even if q>term.
//     q==0: q<=term, wrap<=1, ovf<=1.
//   term_val=0: q stays 0 and every step is a wrap (wrap high each stepped cycle).
//   wrap is 0 in any cycle without a wrap step; back-to-back wraps give a continuous high.
//   term_wr: term<=term_val at the edge; the comparison uses the old term in that same cycle. Independent of clr/load.
//   cap: q_cap<=q (pre-edge value, i.e. before this edge's clr/load/step); cap_vld<=1 for one cycle.
//     cap is independent of all other controls; cap and clr together capture the pre-clear count.
//   Arithmetic is modulo 2**WIDTH internally; the terminal compare is unsigned.
//     q never exceeds 2**WIDTH-1 and no X-propagation on wrap.
//   Reset mid-operation aborts immediately. term returns to MAX_COUNT-1 and pending wrap/cap_vld pulses are dropped.
//   Cascade: stage k+1 cin = stage k cout. Ripple is combinational within one cycle; no extra latency.
//   Latency: q, wrap, ovf, q_cap, cap_vld change 1 edge after inputs. at_max and cout are combinational from q/dir/enb/cin.
// TESTING
//   Default params, enb=cin=1, dir=0, 12 edges -> q 1..9,0,1,2; wrap high only the cycle q=0 first appears; ovf=1 thereafter.
//   dir=1 from q=0 -> q=9,8,7; wrap pulses once at the 0->9 step; at_max=1 only while q=0.
//   q=5, clr=load=1, load_val=7 -> q=0, ovf=0; next edge load=1 alone -> q=7.
//   term_wr with term_val=3 while q=6, up-step -> q=0 and wrap=1. term_val=0: q stays 0 and wrap is high every stepped cycle.
//   q=4, cap=1 together with clr=1 -> q_cap=4, cap_vld high exactly 1 cycle, q=0.
//   Two cascaded WIDTH=4/MAX_COUNT=10 stages, 100 steps -> {hi,lo} reads 0..99, then 0 with hi.wrap.
//     Async rst_s_n low mid-count -> all outputs reset without a clock edge.

Source files
------------

// File: rtl/dsadc_mod_counter_if.sv
// Control/status bundle for dsadc_mod_counter; master drives controls, slave is the counter.
interface dsadc_mod_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             enb;
   logic             cin;
   logic             dir;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             term_wr;
   logic [WIDTH-1:0] term_val;
   logic             cap;
   logic [WIDTH-1:0] q;
   logic             at_max;
   logic             cout;
   logic             wrap;
   logic             ovf;
   logic [WIDTH-1:0] q_cap;
   logic             cap_vld;

   modport master (
      output enb, cin, dir, clr, load, load_val, term_wr, term_val, cap,
      input  q, at_max, cout, wrap, ovf, q_cap, cap_vld
   );

   modport slave (
      input  enb, cin, dir, clr, load, load_val, term_wr, term_val, cap,
      output q, at_max, cout, wrap, ovf, q_cap, cap_vld
   );
endinterface

// File: rtl/dsadc_mod_counter.sv
// Up/down modulus counter with programmable terminal, clear/load, carry cascade,
// sticky overflow and a capture register for the DSADC integrate/de-integrate timing path.
module dsadc_mod_counter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_COUNT = 10
) (
   input  logic                 clk,
   input  logic                 rst_s_n,
   dsadc_mod_counter_if.slave   bus
);

   if ((MAX_COUNT < 2) || (longint'(MAX_COUNT) > (64'd1 << WIDTH))) begin : g_bad_max_count
      $error("dsadc_mod_counter: MAX_COUNT out of range 2..2**WIDTH");
   end

   localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(MAX_COUNT - 1);

   logic [WIDTH-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] term_q,  term_d;
   logic [WIDTH-1:0] qcap_q,  qcap_d;
   logic             wrap_q,  wrap_d;
   logic             ovf_q,   ovf_d;
   logic             capv_q,  capv_d;
   logic             step;
   logic             at_max;

   assign step   = bus.enb & bus.cin;
   assign at_max = bus.dir ? (cnt_q == '0) : (cnt_q >= term_q);

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      term_d = bus.term_wr ? bus.term_val : term_q;
      qcap_d = bus.cap ? cnt_q : qcap_q;
      capv_d = bus.cap;
      if (bus.clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (bus.load) begin
         cnt_d = bus.load_val;
      end else if (step) begin
         // at_max uses the pre-write terminal, so a same-cycle term_wr only affects later steps
         if (at_max) begin
            cnt_d  = bus.dir ? term_q : '0;
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
         end else begin
            cnt_d = bus.dir ? cnt_q - 1'b1 : cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_s_n) begin
      if (!rst_s_n) begin
         cnt_q  <= '0;
         term_q <= TERM_RST;
         qcap_q <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
         capv_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         term_q <= term_d;
         qcap_q <= qcap_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
         capv_q <= capv_d;
      end
   end

   assign bus.q       = cnt_q;
   assign bus.at_max  = at_max;
   assign bus.cout    = at_max & step;
   assign bus.wrap    = wrap_q;
   assign bus.ovf     = ovf_q;
   assign bus.q_cap   = qcap_q;
   assign bus.cap_vld = capv_q;

endmodule
